// File: rtl/dispatch_pulse.sv
// 1-to-TOTAL dispatcher: tagged input words are steered into per-destination FIFOs,
// each drained by its own rdy/stb pulse handshake. Words that cannot be accepted are dropped and counted.
module dispatch_pulse #(
    parameter int TOTAL = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_stb,
    input  logic [$clog2(TOTAL)-1:0] in_dest,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_rdy,
    input  logic [TOTAL-1:0]         out_rdy,
    output logic [TOTAL-1:0]         out_stb,
    output logic [TOTAL*WIDTH-1:0]   out_data,
    output logic [TOTAL-1:0]         busy,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);
    localparam int DEST_W = $clog2(TOTAL);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SLOTS  = 1 << DEST_W;

    logic [TOTAL-1:0] w_full;
    logic [SLOTS-1:0] w_accept_mask;
    logic             w_drop;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;

    // Index codes beyond TOTAL-1 stay 0 in the mask, so out-of-range destinations are never ready.
    always_comb begin
        w_accept_mask = '0;
        w_accept_mask[TOTAL-1:0] = ~w_full;
    end

    assign in_rdy = w_accept_mask[in_dest];
    assign w_drop = in_stb & ~in_rdy;

    for (genvar i = 0; i < TOTAL; i++) begin : g_dest
        logic [DEPTH*WIDTH-1:0] r_mem;
        logic [PTR_W-1:0]       r_wptr;
        logic [PTR_W-1:0]       r_rptr;
        logic [CNT_W-1:0]       r_count;
        logic [WIDTH-1:0]       r_hold;
        logic                   w_push;
        logic                   w_pop;
        logic                   w_busy;
        logic [WIDTH-1:0]       w_head;

        assign w_busy    = (r_count != '0);
        assign w_full[i] = (r_count == CNT_W'(DEPTH));
        assign w_push    = in_stb & in_rdy & (in_dest == DEST_W'(i));
        assign w_pop     = w_busy & out_rdy[i];
        assign w_head    = r_mem[WIDTH*int'(r_rptr) +: WIDTH];

        assign busy[i]                    = w_busy;
        assign out_stb[i]                 = w_pop;
        // r_hold keeps the last popped word visible once the FIFO runs empty.
        assign out_data[WIDTH*i +: WIDTH] = w_busy ? w_head : r_hold;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mem   <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
                r_hold  <= '0;
            end else begin
                if (w_push) begin
                    r_mem[WIDTH*int'(r_wptr) +: WIDTH] <= in_data;
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                    r_hold <= w_head;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: doc/dispatch_pulse.md
Name: dispatch_pulse

Overview:
- 1-to-N dispatcher, the fan-out counterpart of the pulse arbiter.
- Accepts one tagged input stream (data plus destination index) and delivers each word to one of TOTAL consumers.
- Each destination has its own DEPTH-entry FIFO and the same rdy/stb pulse handshake the arbiter uses on its output.
- Placed between a single command/response source and per-unit sinks, so a stalled sink never blocks the others.

Parameters:
- TOTAL, 4, number of destinations; legal range 2..16.
- WIDTH, 8, data word width in bits.
- DEPTH, 2, entries per destination FIFO; power of 2, legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_stb  input  1  source offers a word this cycle (single-cycle pulse per word).
- in_dest  input  $clog2(TOTAL)  destination index of the offered word.
- in_data  input  WIDTH  offered word.
- in_rdy  output  1  selected destination FIFO can accept this cycle.
- out_rdy  input  TOTAL  per-consumer ready.
- out_stb  output  TOTAL  per-destination transfer pulse.
- out_data  output  TOTAL*WIDTH  head word of each FIFO; slice i is [WIDTH*i +: WIDTH].
- busy  output  TOTAL  FIFO i non-empty.
- overflow  output  1  sticky: at least one word has been dropped.
- drop_cnt  output  8  saturating count of dropped words.

Behaviour:
- Reset (rst_n low, asynchronous): all FIFO pointers and occupancy counts clear; storage clears to 0.
  - Outputs while in reset: busy=0, out_stb=0, out_data=0, overflow=0, drop_cnt=0.
  - in_rdy=1 whenever in_dest is a valid index.
  - Deassertion is taken synchronously to clk. Reset mid-transfer discards all queued words, with no out_stb.
- in_rdy is combinational: ~full[in_dest] AND (in_dest < TOTAL).
- Push: in_stb & in_rdy at a rising edge writes in_data into FIFO[in_dest] and increments its occupancy.
- Drop: in_stb & ~in_rdy, caused by a full FIFO or an out-of-range index (TOTAL not a power of 2).
  - The word is discarded and no FIFO changes.
  - overflow is set and stays set until reset.
  - drop_cnt increments and saturates at 255.
- Latency: a word pushed into an empty FIFO appears on out_data slice i, with busy[i]=1, in the cycle after the push edge. There is no combinational bypass from in_data to out_data.
- out_stb[i] = busy[i] & out_rdy[i], combinational, matching the arbiter's out_stb semantics.
  - Pop happens at the rising edge where out_stb[i]=1; the read pointer advances and the next entry (or nothing) becomes visible after that edge.
  - A consumer holding out_rdy high drains one word per cycle.
- out_data slice i is the FIFO head whenever busy[i]=1. When busy[i]=0 it is undefined to consumers and must not be sampled; the RTL holds the last value.
- Same-cycle push and pop on one FIFO:
  - Not full: both happen and occupancy is unchanged.
  - Full: in_rdy is computed from full only, so the push is dropped even though a pop occurs that edge. This is intentional; there is no look-ahead.
- Destinations are fully independent. A full or stalled FIFO j never affects in_rdy for in_dest≠j, nor out_stb/out_data of other slices.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The occupancy counter is $clog2(DEPTH)+1 bits; full when it equals DEPTH, empty when 0.
- Sources use in_rdy to avoid drops. The block never backpressures by stalling; it only drops and counts.

Test Plan:
- Reset, then push 0xA5 to dest 2 with out_rdy=0 -> busy=4'b0100 the next cycle, out_data[23:16]=0xA5, out_stb=0. Raise out_rdy[2] -> out_stb[2] pulses for 1 cycle, then busy=0.
- Fill dest 1 with 0x11, 0x22 (DEPTH=2), out_rdy=0 -> in_rdy=0 for in_dest=1 and 1 for in_dest=0. A third push of 0x33 -> dropped, overflow=1, drop_cnt=1, FIFO still holds 0x11, 0x22.
- Dest 1 full, same cycle: out_rdy[1]=1 and push 0x44 to dest 1 -> 0x11 popped, 0x44 dropped, drop_cnt increments, remaining entry is 0x22.
- Continuous push of 0x00..0x0F alternating dest 0/3, with out_rdy=4'b1001 -> each consumer receives its 8 words in order, with no drops and no out_stb on dests 1/2.
- Fill all FIFOs, assert rst_n=0 asynchronously mid-cycle -> busy, out_stb, overflow and drop_cnt go to 0 without waiting for a clock edge. After release, the first pushed word is delivered correctly.
- Force 300 drops into a full FIFO -> drop_cnt saturates at 255 and overflow stays 1. With TOTAL=3, push in_dest=3 -> in_rdy=0 and the word is dropped.
